in_service_ctrl: RTL
====================

Name: in_service_ctrl

Overview:
Parametrised, clocked in-service tracker for the programmable interrupt controller. It generalises the fixed 8-level combinational in-service logic to NUM_LEVELS levels. It owns the in-service register and the rotating priority pointer, and executes acknowledge, auto-EOI, specific/non-specific EOI, rotate-on-EOI and set-priority commands. Sits between the priority resolver (ack source) and the command decoder (EOI/priority source); its outputs feed the resolver for nesting decisions.

Parameters:
NUM_LEVELS, 8, number of interrupt levels (2..32)
LEVEL_W, $clog2(NUM_LEVELS), width of level-index fields

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ack_valid  input  1  latch ack_level into in-service this cycle
ack_level  input  LEVEL_W  level being acknowledged
auto_eoi  input  1  auto-EOI mode: ack does not set ISR bit
auto_rotate  input  1  with auto_eoi: rotate priority on each ack
eoi_valid  input  1  EOI command strobe
eoi_specific  input  1  1 = specific EOI on eoi_level, 0 = non-specific
eoi_rotate  input  1  rotate priority on the EOI'd level
eoi_level  input  LEVEL_W  target level for specific EOI
set_priority_valid  input  1  set lowest-priority level, no ISR change
set_priority_level  input  LEVEL_W  new lowest-priority level
special_mask_mode  input  1  enable special mask mode
interrupt_mask  input  NUM_LEVELS  mask register; excluded from in-service resolution when special_mask_mode=1
in_service_register  output  NUM_LEVELS  registered ISR
highest_level_in_service  output  NUM_LEVELS  one-hot highest-priority unmasked ISR bit, 0 if none
lowest_priority  output  LEVEL_W  registered lowest-priority level
eoi_error  output  1  registered one-cycle pulse: EOI had nothing to clear

Behaviour:
- All state updates on rising clock; reset is synchronous, active-high, and overrides every command in the same cycle.
- Reset values: in_service_register=0, lowest_priority=NUM_LEVELS-1 (level 0 highest), eoi_error=0, highest_level_in_service=0.
- Priority order: highest = (lowest_priority+1) mod NUM_LEVELS, then ascending with wrap; lowest_priority itself is last.
- eligible = in_service_register & (special_mask_mode ? ~interrupt_mask : all-ones).
- highest_level_in_service: combinational from registered eligible and lowest_priority. Updates 1 cycle after the ISR/pointer change. Never more than one bit set.
- Ack, auto_eoi=0: ISR[ack_level] <= 1 next cycle.
- Ack, auto_eoi=1: ISR unchanged. If auto_rotate=1, lowest_priority <= ack_level.
- Non-specific EOI: clears the bit in highest_level_in_service (current cycle value). If eoi_rotate=1, lowest_priority <= that level. If eligible=0: no ISR or pointer change, eoi_error pulses.
- Specific EOI: ISR[eoi_level] <= 0. If eoi_rotate=1, lowest_priority <= eoi_level even if the bit was already clear. eoi_error pulses if the bit was already clear.
- Set priority: lowest_priority <= set_priority_level.
- Same-cycle precedence:
  - EOI is evaluated on the pre-update ISR; ack is applied after it, so if both target the same level, the bit ends set.
  - Pointer writes: EOI rotate > auto-rotate ack > set_priority.
- Out-of-range levels (>= NUM_LEVELS, when not a power of two):
  - ack: ignored.
  - specific EOI: ignored, eoi_error pulses.
  - set_priority: ignored.
- Width rules: all rotation arithmetic is modulo NUM_LEVELS, not 2^LEVEL_W.
- eoi_error is 0 in every cycle without eoi_valid.
- Mode inputs (auto_eoi, special_mask_mode, mask) are sampled the same cycle as the command they qualify; changing them mid-stream alters no stored state.

Test Plan:
- Reset then idle -> ISR=0x00, lowest_priority=7, highest=0x00, eoi_error=0. Assert reset while ISR=0xFF -> all reset values next cycle.
- Ack level 3, then level 1 -> ISR=0x0A, highest=0x02. Non-specific EOI -> ISR=0x08, highest=0x08. Non-specific EOI -> ISR=0x00. Third non-specific EOI -> eoi_error pulse, ISR stays 0.
- ISR=0x24, rotate-on-non-specific EOI -> bit 2 cleared, lowest_priority=2, highest=0x20. Ack 1 and 5 -> ISR=0x22, highest=0x20 (level 5 outranks 1 after rotation).
- Auto-EOI with auto_rotate, ack 6 -> ISR unchanged, lowest_priority=6. Same cycle as set_priority_valid level 2 -> lowest_priority=6.
- ISR=0x11, special_mask_mode=1, mask=0x01 -> highest=0x10. Non-specific EOI clears bit 4 only -> ISR=0x01, highest=0x00.
- Same-cycle specific EOI level 4 and ack level 4 on ISR=0x10 -> ISR=0x10, no eoi_error. NUM_LEVELS=5, ack level 6 -> ignored. set_priority 4 -> highest priority wraps to level 0.

Source files
------------

// File: rtl/in_service_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// in_service_ctrl_if : command/status bundle between PIC control and tracker
// Rev 1.0
// ---------------------------------------------------------------------------
interface in_service_ctrl_if #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
);
  logic                  ack_valid;
  logic [LEVEL_W-1:0]    ack_level;
  logic                  auto_eoi;
  logic                  auto_rotate;
  logic                  eoi_valid;
  logic                  eoi_specific;
  logic                  eoi_rotate;
  logic [LEVEL_W-1:0]    eoi_level;
  logic                  set_priority_valid;
  logic [LEVEL_W-1:0]    set_priority_level;
  logic                  special_mask_mode;
  logic [NUM_LEVELS-1:0] interrupt_mask;
  logic [NUM_LEVELS-1:0] in_service_register;
  logic [NUM_LEVELS-1:0] highest_level_in_service;
  logic [LEVEL_W-1:0]    lowest_priority;
  logic                  eoi_error;

  modport master (
    output ack_valid, ack_level, auto_eoi, auto_rotate,
           eoi_valid, eoi_specific, eoi_rotate, eoi_level,
           set_priority_valid, set_priority_level,
           special_mask_mode, interrupt_mask,
    input  in_service_register, highest_level_in_service,
           lowest_priority, eoi_error
  );

  modport slave (
    input  ack_valid, ack_level, auto_eoi, auto_rotate,
           eoi_valid, eoi_specific, eoi_rotate, eoi_level,
           set_priority_valid, set_priority_level,
           special_mask_mode, interrupt_mask,
    output in_service_register, highest_level_in_service,
           lowest_priority, eoi_error
  );
endinterface
`default_nettype wire

// File: rtl/in_service_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// in_service_ctrl : in-service register and rotating priority for NUM_LEVELS
// Rev 1.0
// ---------------------------------------------------------------------------
module in_service_ctrl #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  wire logic         clock,
  input  wire logic         reset,
  in_service_ctrl_if.slave  bus
);
  localparam logic [LEVEL_W:0] c_NUM_LEVELS = (LEVEL_W+1)'(NUM_LEVELS);

  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [LEVEL_W-1:0]    lp_q, lp_d;
  logic                  err_q, err_d;

  logic [NUM_LEVELS-1:0] w_eligible;
  logic [NUM_LEVELS-1:0] w_highest;
  logic [LEVEL_W-1:0]    w_hi_lvl;
  logic                  w_hi_found;
  logic                  w_ack_ok;
  logic                  w_eoi_ok;
  logic                  w_sp_ok;

  assign w_eligible = isr_q & (bus.special_mask_mode ? ~bus.interrupt_mask
                                                     : {NUM_LEVELS{1'b1}});
  assign w_ack_ok   = {1'b0, bus.ack_level} < c_NUM_LEVELS;
  assign w_eoi_ok   = {1'b0, bus.eoi_level} < c_NUM_LEVELS;
  assign w_sp_ok    = {1'b0, bus.set_priority_level} < c_NUM_LEVELS;

  // Walk levels from lowest_priority+1 with wrap; the first eligible one wins.
  always_comb begin : p_resolve
    logic [LEVEL_W:0] idx;
    idx        = '0;
    w_hi_found = 1'b0;
    w_hi_lvl   = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      idx = {1'b0, lp_q} + (LEVEL_W+1)'(i + 1);
      if (idx >= c_NUM_LEVELS) idx = idx - c_NUM_LEVELS;
      if (!w_hi_found && w_eligible[idx[LEVEL_W-1:0]]) begin
        w_hi_found = 1'b1;
        w_hi_lvl   = idx[LEVEL_W-1:0];
      end
    end
  end

  always_comb begin : p_onehot
    w_highest = '0;
    if (w_hi_found) w_highest[w_hi_lvl] = 1'b1;
  end

  always_comb begin : p_next
    logic               eoi_rot;
    logic [LEVEL_W-1:0] eoi_rot_lvl;
    isr_d       = isr_q;
    lp_d        = lp_q;
    err_d       = 1'b0;
    eoi_rot     = 1'b0;
    eoi_rot_lvl = '0;

    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        if (!w_eoi_ok) begin
          err_d = 1'b1;
        end else begin
          err_d                 = ~isr_q[bus.eoi_level];
          isr_d[bus.eoi_level]  = 1'b0;
          eoi_rot               = bus.eoi_rotate;
          eoi_rot_lvl           = bus.eoi_level;
        end
      end else if (!w_hi_found) begin
        err_d = 1'b1;
      end else begin
        isr_d[w_hi_lvl] = 1'b0;
        eoi_rot         = bus.eoi_rotate;
        eoi_rot_lvl     = w_hi_lvl;
      end
    end

    // Ack lands after the EOI clear so a same-level pair leaves the bit set.
    if (bus.ack_valid && w_ack_ok && !bus.auto_eoi) isr_d[bus.ack_level] = 1'b1;

    if (eoi_rot)
      lp_d = eoi_rot_lvl;
    else if (bus.ack_valid && w_ack_ok && bus.auto_eoi && bus.auto_rotate)
      lp_d = bus.ack_level;
    else if (bus.set_priority_valid && w_sp_ok)
      lp_d = bus.set_priority_level;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q <= '0;
      lp_q  <= LEVEL_W'(NUM_LEVELS - 1);
      err_q <= 1'b0;
    end else begin
      isr_q <= isr_d;
      lp_q  <= lp_d;
      err_q <= err_d;
    end
  end

  assign bus.in_service_register      = isr_q;
  assign bus.highest_level_in_service = w_highest;
  assign bus.lowest_priority          = lp_q;
  assign bus.eoi_error                = err_q;

endmodule
`default_nettype wire
